// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO family: width math and
// parameter-legality checks evaluated at elaboration time.
package fifo_pkg;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    // Pointer width for a given depth.
    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction

    // Count width: one extra bit so that the value DEPTH is representable.
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // True when a parameter set describes a legal FIFO.
    function automatic bit params_ok(input int width, input int depth,
                                     input int af_thresh, input int ae_thresh);
        return (width >= 1) && (depth >= 4) && is_pow2(depth)
            && (af_thresh >= 1) && (af_thresh <= depth)
            && (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH simple dual-port storage: one synchronous write port and
// one registered read port. Written so synthesis infers a RAM.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port: store the word at the write address.
    // NOTE: the array has no reset so it can map onto RAM macros; reading an unwritten entry is prevented by the occupancy logic.
    always_ff @(posedge clk) begin
        if (we_i) begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port: capture the addressed word, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, threshold
// flags, sticky error flags and the read/write accept logic.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    wr,
    input  logic                    rd,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        data_out,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [cnt_w(DEPTH)-1:0] fifo_cnt,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    if (!params_ok(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
        $error("sync_fifo_param: illegal WIDTH/DEPTH/threshold combination");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             rd_acc;
    logic             wr_acc;

    // Status decodes come straight off the registered count.
    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == DEPTH_C);
    assign almost_empty = (cnt_q <= AE_C);
    assign almost_full  = (cnt_q >= AF_C);
    assign fifo_cnt     = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Accept logic: a full FIFO takes a write only alongside an accepted
    // read; an empty FIFO never takes a read (no write-through bypass).
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc);

    // Next-state for pointers, count and sticky error flags.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        // A new error outranks a same-cycle clear.
        ovf_d = (wr & ~wr_acc) | (ovf_q & ~err_clr);
        udf_d = (rd & ~rd_acc) | (udf_q & ~err_clr);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed, table-driven bench for sync_fifo_param at WIDTH=8, DEPTH=8,
// AF_THRESH=6, AE_THRESH=1.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] data_in;
    logic             wr;
    logic             rd;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [3:0]       fifo_cnt;
    logic             overflow;
    logic             underflow;

    int n_checks;
    int n_fail;

    sync_fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .wr           (wr),
        .rd           (rd),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fifo_cnt     (fifo_cnt),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        logic [3:0] cnt;
        logic [7:0] dout;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];

    // Observed bundle: {cnt, dout, empty, full, almost_empty, almost_full, ovf, udf}
    function automatic logic [17:0] expect_obs(input logic [3:0] cnt, input logic [7:0] dout,
                                               input logic ovf, input logic udf);
        logic e, f, ae, af;
        e  = (cnt == 4'd0);
        f  = (cnt == 4'd8);
        ae = (cnt <= 4'd1);
        af = (cnt >= 4'd6);
        return {cnt, dout, e, f, ae, af, ovf, udf};
    endfunction

    function automatic logic [17:0] actual_obs();
        return {fifo_cnt, data_out, empty, full, almost_empty, almost_full, overflow, underflow};
    endfunction

    function automatic vec_t mk(input logic w, input logic r, input logic c, input logic [7:0] d,
                                input int cnt, input logic [7:0] dout, input logic ovf, input logic udf);
        vec_t v;
        v.wr = w; v.rd = r; v.clr = c; v.din = d;
        v.cnt = 4'(cnt); v.dout = dout; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        @(negedge clk);
        wr = w; rd = r; err_clr = c; data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; data_in = '0;

        // Vector table
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 1));      // read on empty after reset
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 0, 0));      // clear underflow
        for (int i = 0; i < 8; i++)                               // fill 0x10..0x17
            vecs.push_back(mk(1, 0, 0, 8'(8'h10 + i), i + 1, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h18, 8, 8'h00, 1, 0));      // 9th write rejected
        vecs.push_back(mk(1, 0, 1, 8'h19, 8, 8'h00, 1, 0));      // clear vs new error: set wins
        vecs.push_back(mk(0, 0, 1, 8'h00, 8, 8'h00, 0, 0));      // clear overflow
        vecs.push_back(mk(1, 1, 0, 8'hAA, 8, 8'h10, 0, 0));      // full: rd+wr
        for (int i = 0; i < 7; i++)                               // drain 0x11..0x17
            vecs.push_back(mk(0, 1, 0, 8'h00, 7 - i, 8'(8'h11 + i), 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'hAA, 0, 0));      // 0xAA comes out last
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'hAA, 0, 1));      // read on empty, dout holds
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'hAA, 0, 0));      // clear
        vecs.push_back(mk(1, 1, 0, 8'h55, 1, 8'hAA, 0, 1));      // empty: rd+wr, write only
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h55, 0, 1));      // next read returns 0x55
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h55, 0, 0));      // clear

        // Reset state
        #12;
        check("reset_state", 32'(actual_obs()), 32'(expect_obs(4'd0, 8'h00, 1'b0, 1'b0)));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            check($sformatf("vec%0d", i), 32'(actual_obs()),
                  32'(expect_obs(vecs[i].cnt, vecs[i].dout, vecs[i].ovf, vecs[i].udf)));
        end

        // Wrap: preload three words, then 20 cycles of rd+wr at occupancy 3.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 8'(i));
            check($sformatf("wrap_pre%0d", i), 32'(fifo_cnt), 32'(i + 1));
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 8'(i + 3));
            check($sformatf("wrap%0d", i), 32'(actual_obs()),
                  32'(expect_obs(4'd3, 8'(i), 1'b0, 1'b0)));
        end
        step(0, 0, 1, 8'h00);
        check("wrap_clr", 32'({overflow, underflow, fifo_cnt}), 32'({1'b0, 1'b0, 4'd3}));

        // Mid-stream asynchronous reset at occupancy 5.
        step(1, 0, 0, 8'hE0);
        step(1, 0, 0, 8'hE1);
        check("pre_reset_cnt", 32'(fifo_cnt), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(actual_obs()), 32'(expect_obs(4'd0, 8'h00, 1'b0, 1'b0)));
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
        rst_n = 1'b1;
        step(0, 1, 0, 8'h00);
        check("post_reset_rd", 32'(actual_obs()), 32'(expect_obs(4'd0, 8'h00, 1'b0, 1'b1)));

        @(negedge clk);
        rd = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
